// File: rtl/hart_sched.sv
// Purpose : per-hart IDLE/ACTIVE/PEND tracker plus round-robin selection of the hart fetched next.
// Latency : events at edge N change state at N and hart_id/issue_en at N+1; hidle/hart_* /acti_cnt are combinational.
// Backpr. : stall freezes hart_id and issue_en (issue_en still drops if the frozen hart is killed or suspended).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall               holds the issue selection
//   hstart/hs_id        start an IDLE hart
//   hkill/hk_id         send any hart to IDLE (highest priority)
//   set_pend/sp_id      suspend an ACTIVE hart
//   clr_pend/cp_id      resume a PEND hart
//   hidle               hart hs_id is IDLE (current state, no bypass)
//   hart_id/issue_en    registered issue selection
//   hart_acti/hart_idle per-hart ACTIVE / IDLE flags
//   acti_cnt            number of ACTIVE harts
module hart_sched #(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2,
    parameter int BOOT_HART = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 hstart,
    input  logic [HART_ID_W-1:0] hs_id,
    input  logic                 hkill,
    input  logic [HART_ID_W-1:0] hk_id,
    input  logic                 set_pend,
    input  logic [HART_ID_W-1:0] sp_id,
    input  logic                 clr_pend,
    input  logic [HART_ID_W-1:0] cp_id,
    output logic                 hidle,
    output logic [HART_ID_W-1:0] hart_id,
    output logic                 issue_en,
    output logic [HART_NUM-1:0]  hart_acti,
    output logic [HART_NUM-1:0]  hart_idle,
    output logic [HART_ID_W:0]   acti_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_PEND   = 2'b10
    } hstate_t;

    hstate_t hstate [HART_NUM];

    logic [HART_NUM-1:0]  hart_pend;
    logic [HART_NUM-1:0]  kill_vec;
    logic [HART_NUM-1:0]  start_vec;
    logic [HART_NUM-1:0]  susp_vec;
    logic [HART_NUM-1:0]  resume_vec;
    logic [HART_NUM-1:0]  cand;
    logic [HART_ID_W-1:0] next_id;
    logic [HART_ID_W-1:0] idx;
    logic                 found;

    // State decode; the unused encoding 2'b11 falls out as IDLE.
    always_comb begin
        hart_acti = '0;
        hart_pend = '0;
        hart_idle = '0;
        for (int i = 0; i < HART_NUM; i++) begin
            hart_acti[i] = (hstate[i] == ST_ACTIVE);
            hart_pend[i] = (hstate[i] == ST_PEND);
            hart_idle[i] = !hart_acti[i] && !hart_pend[i];
        end
    end

    assign hidle = hart_idle[hs_id];

    always_comb begin
        acti_cnt = '0;
        for (int i = 0; i < HART_NUM; i++) begin
            acti_cnt = acti_cnt + {{HART_ID_W{1'b0}}, hart_acti[i]};
        end
    end

    // One-hot event vectors, each already qualified by the source state it acts on.
    always_comb begin
        kill_vec   = '0;
        start_vec  = '0;
        susp_vec   = '0;
        resume_vec = '0;
        if (hkill)
            kill_vec[hk_id] = 1'b1;
        if (hstart && hart_idle[hs_id])
            start_vec[hs_id] = 1'b1;
        if (set_pend && hart_acti[sp_id])
            susp_vec[sp_id] = 1'b1;
        if (clr_pend && hart_pend[cp_id])
            resume_vec[cp_id] = 1'b1;
    end

    // Harts leaving ACTIVE this edge are excluded now; harts entering ACTIVE
    // only show up in hart_acti next cycle, so they join one cycle later.
    assign cand = hart_acti & ~kill_vec & ~susp_vec;

    // Round-robin search starting after the current hart; k == HART_NUM wraps
    // back onto the current hart so it is checked last.
    always_comb begin
        found   = 1'b0;
        next_id = hart_id;
        idx     = hart_id;
        for (int k = 1; k <= HART_NUM; k++) begin
            idx = hart_id + HART_ID_W'(k);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                next_id = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HART_NUM; i++) begin
                hstate[i] <= (i == BOOT_HART) ? ST_ACTIVE : ST_IDLE;
            end
            hart_id  <= HART_ID_W'(BOOT_HART);
            issue_en <= 1'b1;
        end else begin
            // Kill first, then start (IDLE only), suspend (ACTIVE only), resume (PEND only).
            for (int i = 0; i < HART_NUM; i++) begin
                if (kill_vec[i])
                    hstate[i] <= ST_IDLE;
                else if (start_vec[i])
                    hstate[i] <= ST_ACTIVE;
                else if (susp_vec[i])
                    hstate[i] <= ST_PEND;
                else if (resume_vec[i])
                    hstate[i] <= ST_ACTIVE;
            end

            if (!stall) begin
                if (found) begin
                    hart_id  <= next_id;
                    issue_en <= 1'b1;
                end else begin
                    issue_en <= 1'b0;
                end
            end else if (kill_vec[hart_id] || susp_vec[hart_id]) begin
                // Frozen hart leaves ACTIVE under stall: stop claiming a valid issue.
                issue_en <= 1'b0;
            end
        end
    end

endmodule
